// File: rtl/seg_display_if.sv
`default_nettype none
// ============================================================================
// Module   : seg_display_if
// Purpose  : Handshake/data bundle between the control FSM and the
//            7-segment display controller.
// Signals  : load, value, lz_blank, blink_mask  (master -> slave)
//            busy, done, seg_out                (slave  -> master)
// Revision : 1.0 - initial release
// ============================================================================
interface seg_display_if #(
  parameter int DIGITS = 4,
  parameter int WIDTH  = 14
);
  logic                  load;
  logic [WIDTH-1:0]      value;
  logic                  lz_blank;
  logic [DIGITS-1:0]     blink_mask;
  logic                  busy;
  logic                  done;
  logic [7*DIGITS-1:0]   seg_out;

  modport master (
    output load, value, lz_blank, blink_mask,
    input  busy, done, seg_out
  );

  modport slave (
    input  load, value, lz_blank, blink_mask,
    output busy, done, seg_out
  );
endinterface
`default_nettype wire

// File: rtl/seg_display_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : seg_display_ctrl
// Purpose  : Multi-digit active-low 7-segment controller. A binary value is
//            accepted on load (when not busy), converted to BCD one bit per
//            clock (shift-add-3), then shown with leading-zero blanking,
//            overflow dashes and per-digit blinking.
// Ports    : clk  - system clock (rising edge)
//            rst  - asynchronous active-high reset
//            bus  - seg_display_if.slave: load/value/lz_blank/blink_mask in,
//                   busy/done/seg_out out (digit i at seg_out[7*i+6:7*i],
//                   bit 7*i+6 = segment a ... bit 7*i = segment g)
// Revision : 1.0 - initial release
// ============================================================================
module seg_display_ctrl #(
  parameter int DIGITS    = 4,
  parameter int WIDTH     = 14,
  parameter int BLINK_DIV = 25000000
) (
  input  wire logic     clk,
  input  wire logic     rst,
  seg_display_if.slave  bus
);

  localparam int c_CNT_W   = $clog2(WIDTH);
  localparam int c_BLINK_W = $clog2(BLINK_DIV);
  localparam int c_BCD_W   = 4 * DIGITS;

  localparam logic [c_CNT_W-1:0]   c_LAST_STEP  = c_CNT_W'(WIDTH - 1);
  localparam logic [c_BLINK_W-1:0] c_BLINK_LAST = c_BLINK_W'(BLINK_DIV - 1);

  localparam logic [6:0] c_SEG_DASH  = 7'b1111110;
  localparam logic [6:0] c_SEG_BLANK = 7'b1111111;

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int k = 0; k < n; k++) r = r * 64'd10;
    return r;
  endfunction

  // Largest value that fits in DIGITS decimal digits.
  localparam logic [63:0] c_MAX_VAL = pow10(DIGITS) - 64'd1;

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    case (nib)
      4'd0:    seg_decode = 7'b0000001;
      4'd1:    seg_decode = 7'b1001111;
      4'd2:    seg_decode = 7'b0010010;
      4'd3:    seg_decode = 7'b0000110;
      4'd4:    seg_decode = 7'b1001100;
      4'd5:    seg_decode = 7'b0100100;
      4'd6:    seg_decode = 7'b0100000;
      4'd7:    seg_decode = 7'b0001111;
      4'd8:    seg_decode = 7'b0000000;
      4'd9:    seg_decode = 7'b0000100;
      default: seg_decode = c_SEG_BLANK;
    endcase
  endfunction

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_CONV = 1'b1
  } state_t;

  state_t                 r_state;
  logic                   r_busy;
  logic [c_CNT_W-1:0]     r_step;
  logic [WIDTH-1:0]       r_bin;
  logic [c_BCD_W-1:0]     r_bcd;
  logic                   r_ovf;

  logic [c_BCD_W-1:0]     r_disp_bcd;
  logic                   r_disp_ovf;
  logic                   r_empty;
  logic                   r_committed;   // commit happened on the previous edge
  logic                   r_done;
  logic [7*DIGITS-1:0]    r_seg;

  logic [c_BLINK_W-1:0]   r_blink_cnt;
  logic                   r_blink_phase;

  logic [c_BCD_W-1:0]     w_adj;
  logic [c_BCD_W-1:0]     w_next_bcd;
  logic [WIDTH-1:0]       w_next_bin;
  logic                   w_ovf_in;
  logic                   w_zero_run;
  logic [6:0]             w_digit;
  logic [7*DIGITS-1:0]    w_seg_next;

  assign w_ovf_in = ({{(64-WIDTH){1'b0}}, bus.value} > c_MAX_VAL);

  // One double-dabble step: correct nibbles >= 5, then shift {bcd, bin}.
  always_comb begin
    w_adj = r_bcd;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5) w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
    end
    w_next_bcd = {w_adj[c_BCD_W-2:0], r_bin[WIDTH-1]};
    w_next_bin = {r_bin[WIDTH-2:0], 1'b0};
  end

  // Per-digit output selection. Scanning from the top digit down,
  // w_zero_run stays set while this and every higher digit is zero.
  always_comb begin
    w_seg_next = '1;
    w_zero_run = 1'b1;
    w_digit    = c_SEG_BLANK;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      w_zero_run = w_zero_run & (r_disp_bcd[4*i +: 4] == 4'd0);
      if (r_empty)                                w_digit = c_SEG_BLANK;
      else if (r_disp_ovf)                        w_digit = c_SEG_DASH;
      else if (bus.lz_blank && (i > 0) && w_zero_run) w_digit = c_SEG_BLANK;
      else                                        w_digit = seg_decode(r_disp_bcd[4*i +: 4]);
      // Blinking also hides dashes, so it is applied on top of the above.
      if (!r_empty && bus.blink_mask[i] && r_blink_phase) w_digit = c_SEG_BLANK;
      w_seg_next[7*i +: 7] = w_digit;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_busy        <= 1'b0;
      r_step        <= '0;
      r_bin         <= '0;
      r_bcd         <= '0;
      r_ovf         <= 1'b0;
      r_disp_bcd    <= '0;
      r_disp_ovf    <= 1'b0;
      r_empty       <= 1'b1;
      r_committed   <= 1'b0;
      r_done        <= 1'b0;
      r_seg         <= '1;
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
    end else begin
      r_committed <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.load) begin
            r_bin   <= bus.value;
            r_ovf   <= w_ovf_in;
            r_bcd   <= '0;
            r_step  <= '0;
            r_busy  <= 1'b1;
            r_state <= ST_CONV;
          end
        end
        ST_CONV: begin
          r_bcd  <= w_next_bcd;
          r_bin  <= w_next_bin;
          r_step <= r_step + 1'b1;
          if (r_step == c_LAST_STEP) begin
            r_disp_bcd  <= w_next_bcd;
            r_disp_ovf  <= r_ovf;
            r_empty     <= 1'b0;
            r_committed <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase

      // done is aligned with the first seg_out update after a commit.
      r_done <= r_committed;
      r_seg  <= w_seg_next;

      if (r_blink_cnt == c_BLINK_LAST) begin
        r_blink_cnt   <= '0;
        r_blink_phase <= ~r_blink_phase;
      end else begin
        r_blink_cnt <= r_blink_cnt + 1'b1;
      end
    end
  end

  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.seg_out = r_seg;

endmodule
`default_nettype wire

// File: tb/tb_seg_display_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg_display_ctrl
// Purpose  : Self-checking bench for seg_display_ctrl (DIGITS=4, WIDTH=14,
//            BLINK_DIV=4) against a decimal-arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg_display_ctrl;

  localparam int DIGITS    = 4;
  localparam int WIDTH     = 14;
  localparam int BLINK_DIV = 4;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  int   tb_edges;     // rising edges since reset release

  // Reference model state: what the display should currently hold.
  bit   m_valid;
  int   m_value;

  seg_display_if #(.DIGITS(DIGITS), .WIDTH(WIDTH)) bus ();

  seg_display_ctrl #(
    .DIGITS(DIGITS), .WIDTH(WIDTH), .BLINK_DIV(BLINK_DIV)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) tb_edges <= 0;
    else     tb_edges <= tb_edges + 1;
  end

  function automatic int pow10(input int n);
    int r;
    r = 1;
    for (int k = 0; k < n; k++) r = r * 10;
    return r;
  endfunction

  function automatic logic [6:0] ref_glyph(input int d);
    case (d)
      0: return 7'b0000001;
      1: return 7'b1001111;
      2: return 7'b0010010;
      3: return 7'b0000110;
      4: return 7'b1001100;
      5: return 7'b0100100;
      6: return 7'b0100000;
      7: return 7'b0001111;
      8: return 7'b0000000;
      9: return 7'b0000100;
      default: return 7'b1111111;
    endcase
  endfunction

  // Blink phase that the output register used on the most recent edge.
  function automatic bit ref_phase();
    return bit'(((tb_edges - 1) / BLINK_DIV) % 2);
  endfunction

  // Expected seg_out for the model display given the live inputs.
  function automatic logic [7*DIGITS-1:0] ref_seg();
    logic [7*DIGITS-1:0] r;
    logic [6:0]          g;
    bit                  ph;
    int                  p;
    ph = ref_phase();
    r  = '1;
    for (int i = 0; i < DIGITS; i++) begin
      p = pow10(i);
      if (!m_valid)                                      g = 7'b1111111;
      else if (m_value > pow10(DIGITS) - 1)              g = 7'b1111110;
      else if (bus.lz_blank && i > 0 && m_value < p)     g = 7'b1111111;
      else                                               g = ref_glyph((m_value / p) % 10);
      if (m_valid && bus.blink_mask[i] && ph)            g = 7'b1111111;
      r[7*i +: 7] = g;
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue a load and follow it cycle by cycle to the displayed result.
  // With inject set, a second load is offered while busy (must be ignored).
  task automatic run_load(input int val, input bit inject, input string name);
    logic [7*DIGITS-1:0] exp;
    bus.load  = 1'b1;
    bus.value = WIDTH'(val);
    tick();                               // accept edge
    bus.load  = 1'b0;
    n_checks++;
    if (bus.busy !== 1'b1) begin
      n_fail++; $display("FAIL %s accept_busy: busy=%b required=1", name, bus.busy);
    end
    for (int k = 1; k <= WIDTH; k++) begin
      if (inject && k == 4) begin
        bus.load  = 1'b1;
        bus.value = WIDTH'(5678);
      end else if (inject && k == 5) begin
        bus.load  = 1'b0;
        bus.value = WIDTH'(val);
      end
      tick();
      n_checks++;
      if (bus.busy !== (k < WIDTH)) begin
        n_fail++; $display("FAIL %s busy_step%0d: busy=%b required=%b", name, k, bus.busy, k < WIDTH);
      end
      n_checks++;
      if (bus.done !== 1'b0) begin
        n_fail++; $display("FAIL %s early_done_step%0d: done=%b required=0", name, k, bus.done);
      end
      exp = ref_seg();
      n_checks++;
      if (bus.seg_out !== exp) begin
        n_fail++; $display("FAIL %s old_display_step%0d: seg_out=%h required=%h", name, k, bus.seg_out, exp);
      end
    end
    bus.load = 1'b0;
    tick();                               // edge WIDTH+1: new value appears
    m_valid = 1'b1;
    m_value = val;
    exp = ref_seg();
    n_checks++;
    if (bus.done !== 1'b1) begin
      n_fail++; $display("FAIL %s done_pulse: done=%b required=1", name, bus.done);
    end
    n_checks++;
    if (bus.seg_out !== exp) begin
      n_fail++; $display("FAIL %s new_display: seg_out=%h required=%h", name, bus.seg_out, exp);
    end
    tick();
    n_checks++;
    if (bus.done !== 1'b0) begin
      n_fail++; $display("FAIL %s done_width: done=%b required=0", name, bus.done);
    end
  endtask

  task automatic hold_and_check(input int cycles, input string name);
    logic [7*DIGITS-1:0] exp;
    for (int k = 0; k < cycles; k++) begin
      tick();
      exp = ref_seg();
      n_checks++;
      if (bus.seg_out !== exp || bus.done !== 1'b0 || bus.busy !== 1'b0) begin
        n_fail++;
        $display("FAIL %s cycle%0d: seg_out=%h busy=%b done=%b required seg_out=%h busy=0 done=0",
                 name, k, bus.seg_out, bus.busy, bus.done, exp);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (bus.seg_out !== '1 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_fail++; $display("FAIL reset_values: seg_out=%h busy=%b done=%b required all ones/0/0",
                         bus.seg_out, bus.busy, bus.done);
    end
    rst = 1'b0;
    hold_and_check(100, "reset_idle");
  endtask

  task automatic test_basic();
    bus.lz_blank = 1'b0;
    run_load(1234, 1'b0, "load_1234");
    n_checks++;
    if (bus.seg_out !== {7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100}) begin
      n_fail++; $display("FAIL digits_1234: seg_out=%h required=%h", bus.seg_out,
                         {7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100});
    end
  endtask

  task automatic test_leading_zero();
    bus.lz_blank = 1'b1;
    run_load(7, 1'b0, "lz_7");
    run_load(0, 1'b0, "lz_0");
    n_checks++;
    if (bus.seg_out !== {{3{7'b1111111}}, 7'b0000001}) begin
      n_fail++; $display("FAIL lz_zero_shows_0: seg_out=%h required=%h", bus.seg_out,
                         {{3{7'b1111111}}, 7'b0000001});
    end
    bus.lz_blank = 1'b0;
    tick();
    n_checks++;
    if (bus.seg_out !== {4{7'b0000001}}) begin
      n_fail++; $display("FAIL lz_toggle_off: seg_out=%h required=%h", bus.seg_out, {4{7'b0000001}});
    end
  endtask

  task automatic test_overflow();
    run_load(10000, 1'b0, "ovf_10000");
    n_checks++;
    if (bus.seg_out !== {4{7'b1111110}}) begin
      n_fail++; $display("FAIL ovf_dashes: seg_out=%h required=%h", bus.seg_out, {4{7'b1111110}});
    end
    run_load(9999, 1'b0, "max_9999");
    n_checks++;
    if (bus.seg_out !== {4{7'b0000100}}) begin
      n_fail++; $display("FAIL max_nines: seg_out=%h required=%h", bus.seg_out, {4{7'b0000100}});
    end
  endtask

  task automatic test_ignore_while_busy();
    run_load(1234, 1'b1, "ignore_busy");
    hold_and_check(3, "ignore_busy_after");
  endtask

  task automatic test_blink();
    bus.blink_mask = 4'b0001;
    bus.lz_blank   = 1'b0;
    run_load(1234, 1'b0, "blink_load");
    hold_and_check(20, "blink_alternate");
    run_load(10000, 1'b0, "blink_dash");
    hold_and_check(12, "blink_dash_hold");
    bus.blink_mask = 4'b0000;
    tick();
  endtask

  task automatic test_reset_mid_conversion();
    bus.load  = 1'b1;
    bus.value = WIDTH'(4321);
    tick();
    bus.load  = 1'b0;
    repeat (7) tick();
    rst = 1'b1;
    #1;
    n_checks++;
    if (bus.seg_out !== '1 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset_immediate: seg_out=%h busy=%b done=%b required all ones/0/0",
                         bus.seg_out, bus.busy, bus.done);
    end
    tick();
    rst     = 1'b0;
    m_valid = 1'b0;
    hold_and_check(WIDTH + 4, "mid_reset_no_done");
  endtask

  task automatic test_random();
    int v;
    for (int n = 0; n < 12; n++) begin
      v              = int'($urandom_range(0, (1 << WIDTH) - 1));
      if (n % 3 == 0) v = int'($urandom_range(0, 120));
      bus.lz_blank   = 1'($urandom_range(0, 1));
      bus.blink_mask = 4'($urandom_range(0, 15));
      run_load(v, 1'($urandom_range(0, 1)), "random_load");
      bus.lz_blank   = 1'($urandom_range(0, 1));
      bus.blink_mask = 4'($urandom_range(0, 15));
      hold_and_check(int'($urandom_range(1, 6)), "random_hold");
    end
    bus.blink_mask = 4'b0000;
  endtask

  initial begin
    n_checks       = 0;
    n_fail         = 0;
    m_valid        = 1'b0;
    m_value        = 0;
    rst            = 1'b1;
    bus.load       = 1'b0;
    bus.value      = '0;
    bus.lz_blank   = 1'b0;
    bus.blink_mask = '0;

    test_reset();
    test_basic();
    test_leading_zero();
    test_overflow();
    test_ignore_while_busy();
    test_blink();
    test_reset_mid_conversion();
    test_random();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
